// File: rtl/timestamp_controller.sv
// rtl/timestamp_controller.sv - free-running timestamp counter with start sequencer
module timestamp_controller #(
  parameter int COUNTER_WIDTH = 64,
  parameter int COUNTER_STEP  = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     cmd_valid,
  input  logic [2:0]               cmd_op,
  input  logic [63:0]              cmd_data,
  output logic                     cmd_ready,
  input  logic                     sync_in,
  output logic [COUNTER_WIDTH-1:0] counter,
  output logic                     auto_start,
  output logic                     armed,
  output logic                     cmd_error,
  output logic                     overflow
);

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_START     = 3'd1;
  localparam logic [2:0] OP_STOP      = 3'd2;
  localparam logic [2:0] OP_CLEAR     = 3'd3;
  localparam logic [2:0] OP_LOAD      = 3'd4;
  localparam logic [2:0] OP_ARM_DELAY = 3'd5;
  localparam logic [2:0] OP_ARM_EXT   = 3'd6;
  localparam logic [2:0] OP_CLEAR_ERR = 3'd7;

  // Step widened by one bit so the carry out of the add is the wrap flag.
  localparam logic [COUNTER_WIDTH:0] STEP_EXT = (COUNTER_WIDTH+1)'(COUNTER_STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED_DLY,
    ST_ARMED_EXT,
    ST_RUNNING
  } state_e;

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [31:0]              delay_q, delay_d;
  logic                     error_q, error_d;
  logic                     overflow_q, overflow_d;
  logic                     ready_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     sync_prev_q;

  logic                     cmd_fire;
  logic                     bad_op;
  logic                     sync_rise;
  logic                     arm_event;
  logic [31:0]              delay_arg;
  logic [COUNTER_WIDTH:0]   step_sum;

  assign cmd_fire  = cmd_valid & ready_q;
  // Commands that are only legal while IDLE; elsewhere they flag an error.
  assign bad_op    = (cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD) ||
                     (cmd_op == OP_ARM_DELAY) || (cmd_op == OP_ARM_EXT);
  assign sync_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign delay_arg = cmd_data[31:0];
  assign step_sum  = {1'b0, counter_q} + STEP_EXT;
  // The armed wait ends on the last delay cycle or on a fresh trigger edge.
  assign arm_event = ((state_q == ST_ARMED_DLY) && (delay_q == 32'd1)) ||
                     ((state_q == ST_ARMED_EXT) && sync_rise);

  // Synchronizer and edge detector run continuously so stale levels never trigger.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sync_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state logic: state events first, then accepted command, CLEAR_ERR last.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    delay_d    = delay_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_START: state_d = ST_RUNNING;
            OP_CLEAR: counter_d = '0;
            OP_LOAD:  counter_d = cmd_data[COUNTER_WIDTH-1:0];
            OP_ARM_DELAY: begin
              if (delay_arg == 32'd0) begin
                state_d = ST_RUNNING;
              end else begin
                state_d = ST_ARMED_DLY;
                delay_d = delay_arg;
              end
            end
            OP_ARM_EXT: state_d = ST_ARMED_EXT;
            default: ;
          endcase
        end
      end
      ST_ARMED_DLY, ST_ARMED_EXT: begin
        if (state_q == ST_ARMED_DLY) begin
          delay_d = delay_q - 32'd1;
        end
        // STOP beats a coinciding expiry or trigger edge.
        if (cmd_fire && (cmd_op == OP_STOP)) begin
          state_d = ST_IDLE;
        end else if ((cmd_fire && (cmd_op == OP_START)) || arm_event) begin
          state_d = ST_RUNNING;
        end
        if (cmd_fire && bad_op) begin
          error_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        counter_d = step_sum[COUNTER_WIDTH-1:0];
        if (step_sum[COUNTER_WIDTH]) begin
          overflow_d = 1'b1;
        end
        if (cmd_fire && (cmd_op == OP_STOP)) begin
          state_d = ST_IDLE;
        end
        if (cmd_fire && bad_op) begin
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_fire && (cmd_op == OP_CLEAR_ERR)) begin
      error_d    = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // Main state register; reset drops every output and any pending arm at once.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      counter_q  <= '0;
      delay_q    <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      delay_q    <= delay_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
      ready_q    <= 1'b1;
    end
  end

  assign cmd_ready  = ready_q;
  assign counter    = counter_q;
  assign auto_start = (state_q == ST_RUNNING);
  assign armed      = (state_q == ST_ARMED_DLY) || (state_q == ST_ARMED_EXT);
  assign cmd_error  = error_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_timestamp_controller.sv
// tb/tb_timestamp_controller.sv - scoreboard bench for timestamp_controller
module tb_timestamp_controller;

  localparam int W    = 64;
  localparam int STEP = 1;
  localparam int SS   = 2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_ARMD  = 3'd5;
  localparam logic [2:0] OP_ARME  = 3'd6;
  localparam logic [2:0] OP_CLRE  = 3'd7;

  localparam int M_IDLE = 0;
  localparam int M_DLY  = 1;
  localparam int M_EXT  = 2;
  localparam int M_RUN  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [63:0]   cmd_data = 64'd0;
  logic          sync_in = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  counter;
  logic          auto_start;
  logic          armed;
  logic          cmd_error;
  logic          overflow;

  always #5 clk = ~clk;

  timestamp_controller #(
    .COUNTER_WIDTH(W),
    .COUNTER_STEP (STEP),
    .SYNC_STAGES  (SS)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .sync_in      (sync_in),
    .counter      (counter),
    .auto_start   (auto_start),
    .armed        (armed),
    .cmd_error    (cmd_error),
    .overflow     (overflow)
  );

  typedef struct {
    logic [63:0] cnt;
    logic        run;
    logic        arm;
    logic        err;
    logic        ovf;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   started = 0;
  bit   done = 0;
  bit   sync_lvl = 0;

  // Reference model state
  int          m_state;
  logic [63:0] m_cnt;
  bit          m_err, m_ovf, m_rdy;
  longint      m_dly;
  int          hist[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_cnt   = 64'd0;
    m_err   = 0;
    m_ovf   = 0;
    m_rdy   = 0;
    m_dly   = 0;
    hist.delete();
    for (int i = 0; i < SS + 1; i++) hist.push_back(0);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.cnt = m_cnt;
    e.run = (m_state == M_RUN);
    e.arm = (m_state == M_DLY) || (m_state == M_EXT);
    e.err = m_err;
    e.ovf = m_ovf;
    e.rdy = m_rdy;
    exp_q.push_back(e);
    started = 1;
  endfunction

  // One clock edge of the behaviour described by the command table.
  function automatic void model_edge(bit v, logic [2:0] op, logic [63:0] d, bit s);
    bit          fire;
    bit          rise;
    bit          evt;
    bit          bad;
    logic [64:0] sum;
    fire = v && m_rdy;
    bad  = (op == OP_CLEAR) || (op == OP_LOAD) || (op == OP_ARMD) || (op == OP_ARME);
    hist.push_back(int'(s));
    // A trigger counts when the synchronized level (SS edges old) goes 0 -> 1.
    rise = (hist[hist.size()-1-SS] == 1) && (hist[hist.size()-2-SS] == 0);
    if (hist.size() > 16) void'(hist.pop_front());
    m_rdy = 1;
    case (m_state)
      M_RUN: begin
        sum   = {1'b0, m_cnt} + 65'(STEP);
        m_cnt = sum[63:0];
        if (sum[64]) m_ovf = 1;
        if (fire && op == OP_STOP) m_state = M_IDLE;
        if (fire && bad) m_err = 1;
      end
      M_IDLE: begin
        if (fire) begin
          if (op == OP_START) m_state = M_RUN;
          else if (op == OP_CLEAR) m_cnt = 64'd0;
          else if (op == OP_LOAD) m_cnt = d;
          else if (op == OP_ARME) m_state = M_EXT;
          else if (op == OP_ARMD) begin
            if (d[31:0] == 32'd0) m_state = M_RUN;
            else begin
              m_state = M_DLY;
              m_dly = longint'(d[31:0]);
            end
          end
        end
      end
      default: begin
        evt = (m_state == M_DLY) ? (m_dly == 1) : rise;
        if (m_state == M_DLY) m_dly--;
        if (fire && op == OP_STOP) m_state = M_IDLE;
        else if ((fire && op == OP_START) || evt) m_state = M_RUN;
        if (fire && bad) m_err = 1;
      end
    endcase
    if (fire && op == OP_CLRE) begin
      m_err = 0;
      m_ovf = 0;
    end
  endfunction

  task automatic cyc(bit v, logic [2:0] op, logic [63:0] d);
    @(negedge clk);
    rst_n     = 1'b1;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    sync_in   = sync_lvl;
    model_edge(v, op, d, sync_lvl);
    push_exp();
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) cyc(0, OP_NOP, 64'd0);
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_counter", counter, 64'd0);
    check("rst_auto_start", {63'd0, auto_start}, 64'd0);
    check("rst_armed", {63'd0, armed}, 64'd0);
    check("rst_cmd_error", {63'd0, cmd_error}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    model_reset();
    push_exp();
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      push_exp();
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("counter", counter, mon_e.cnt);
      check("auto_start", {63'd0, auto_start}, {63'd0, mon_e.run});
      check("armed", {63'd0, armed}, {63'd0, mon_e.arm});
      check("cmd_error", {63'd0, cmd_error}, {63'd0, mon_e.err});
      check("overflow", {63'd0, overflow}, {63'd0, mon_e.ovf});
      check("cmd_ready", {63'd0, cmd_ready}, {63'd0, mon_e.rdy});
    end else if (started && !done) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end
  end

  initial begin
    int          hi;
    logic [2:0]  op;
    logic [63:0] d;
    int          r;

    do_reset(3);
    nops(2);

    // LOAD 0x100, START, 10 running cycles, STOP
    cyc(1, OP_LOAD, 64'h100);
    cyc(1, OP_START, 64'd0);
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, OP_NOP, 64'd0);
      hi += int'(auto_start);
    end
    cyc(1, OP_STOP, 64'd0);
    hi += int'(auto_start);
    cyc(0, OP_NOP, 64'd0);
    hi += int'(auto_start);
    check("run_cycles", 64'(hi), 64'd10);
    check("stop_value", counter, 64'h10A);
    nops(20);
    check("frozen_value", counter, 64'h10A);

    // ARM_DELAY 5 cancelled by STOP on the third cycle
    cyc(1, OP_ARMD, 64'd5);
    nops(2);
    cyc(1, OP_STOP, 64'd0);
    nops(8);
    check("cancel_no_start", {63'd0, auto_start}, 64'd0);

    // ARM_DELAY 5 runs to completion
    cyc(1, OP_ARMD, 64'hABCD_0000_0000_0005);
    for (int j = 0; j < 6; j++) begin
      cyc(0, OP_NOP, 64'd0);
      if (j == 4) check("delay_before", {63'd0, auto_start}, 64'd0);
      if (j == 5) check("delay_rise", {63'd0, auto_start}, 64'd1);
    end
    cyc(1, OP_STOP, 64'd0);

    // ARM_EXT with sync already high, then a fresh edge
    sync_lvl = 1;
    nops(4);
    cyc(1, OP_ARME, 64'd0);
    nops(6);
    check("stale_level", {63'd0, armed}, 64'd1);
    sync_lvl = 0;
    nops(3);
    sync_lvl = 1;
    for (int j = 0; j < 5; j++) begin
      cyc(0, OP_NOP, 64'd0);
      if (j == 2) check("sync_before", {63'd0, auto_start}, 64'd0);
      if (j == 3) check("sync_rise", {63'd0, auto_start}, 64'd1);
    end
    cyc(1, OP_STOP, 64'd0);
    sync_lvl = 0;

    // Wrap sets sticky overflow; CLEAR_ERR removes it
    cyc(1, OP_LOAD, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(1, OP_START, 64'd0);
    nops(4);
    cyc(1, OP_STOP, 64'd0);
    nops(3);
    check("overflow_sticky", {63'd0, overflow}, 64'd1);
    cyc(1, OP_CLRE, 64'd0);
    nops(1);
    check("overflow_cleared", {63'd0, overflow}, 64'd0);

    // LOAD while running is an error and leaves the count alone
    cyc(1, OP_START, 64'd0);
    nops(1);
    cyc(1, OP_LOAD, 64'hDEAD_BEEF);
    nops(2);
    check("load_running_err", {63'd0, cmd_error}, 64'd1);
    cyc(1, OP_STOP, 64'd0);
    cyc(1, OP_CLRE, 64'd0);

    // STOP on the edge the delay expires
    cyc(1, OP_ARMD, 64'd3);
    nops(2);
    cyc(1, OP_STOP, 64'd0);
    nops(2);
    check("stop_vs_expiry", {63'd0, auto_start}, 64'd0);

    // Reset mid-RUNNING and mid-ARMED_DLY
    cyc(1, OP_START, 64'd0);
    nops(5);
    do_reset(2);
    cyc(1, OP_START, 64'd0);
    nops(2);
    cyc(1, OP_ARMD, 64'd10);
    nops(3);
    do_reset(2);
    nops(3);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      if ($urandom_range(0, 7) == 0) sync_lvl = ~sync_lvl;
      if (r == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        op = 3'($urandom_range(0, 7));
        d  = {$urandom, $urandom};
        if (op == OP_LOAD && $urandom_range(0, 1) == 1)
          d = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 40));
        if (op == OP_ARMD)
          d = {d[63:32], 32'($urandom_range(0, 12))};
        cyc($urandom_range(0, 2) != 0, op, d);
      end
    end
    nops(2);
    done = 1;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timestamp_controller.md
# timestamp_controller

Free-running 64-bit timestamp generator and start sequencer that drives the `counter` and `auto_start` inputs of each DAC controller in the RFSoC design. The timestamp controller accepts host commands over a simple valid/ready port from the AXI register decoder. It starts, stops, loads or arms the timestamp, including delayed and externally triggered starts. Every DAC controller's RTO core compares its queued timestamps against this counter, so one instance serves all DAC channels.

## Interface
- `COUNTER_WIDTH`, 64, timestamp width.
- `COUNTER_STEP`, 1, increment added per cycle while running.
- `SYNC_STAGES`, 2, synchronizer depth on `sync_in` (minimum 2).
- `s_axi_aclk`  in  1  sole clock; counter time base.
- `s_axi_aresetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command strobe.
- `cmd_op`  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 LOAD, 5 ARM_DELAY, 6 ARM_EXT, 7 CLEAR_ERR.
- `cmd_data`  in  64  operand: LOAD value; ARM_DELAY uses [31:0] as the delay.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `sync_in`  in  1  asynchronous external start trigger.
- `counter`  out  COUNTER_WIDTH  registered timestamp.
- `auto_start`  out  1  high exactly while the state is RUNNING.
- `armed`  out  1  high in ARMED_DLY or ARMED_EXT.
- `cmd_error`  out  1  sticky: illegal command for the current state.
- `overflow`  out  1  sticky: counter wrapped.

## Operation
- States: IDLE, ARMED_DLY, ARMED_EXT, RUNNING. Reset state is IDLE.
- Reset values: `counter`=0, `auto_start`=0, `armed`=0, `cmd_error`=0, `overflow`=0, `cmd_ready`=0. `cmd_ready` goes to 1 on the first edge after reset is released.
- `cmd_ready` is held at 1 outside reset. No command backpressure.
- IDLE:
  - START → RUNNING.
  - CLEAR → `counter`=0.
  - LOAD → `counter`=`cmd_data`.
  - ARM_DELAY with D>0 → ARMED_DLY, `delay_cnt`=D. With D=0 it is identical to START.
  - ARM_EXT → ARMED_EXT.
  - STOP is a NOP.
- ARMED_DLY: `delay_cnt` decrements each cycle. The transition to RUNNING occurs on the edge at which `delay_cnt`==1, so the state is ARMED for exactly D cycles.
- ARMED_EXT: a rising edge of the synchronized `sync_in` → RUNNING.
- In either ARMED state:
  - STOP → IDLE (arm cancelled).
  - START → RUNNING immediately.
  - CLEAR, LOAD and re-ARM set `cmd_error` and are otherwise ignored.
- RUNNING: `counter` += `COUNTER_STEP` every cycle, modulo 2^COUNTER_WIDTH.
  - If the add carries out, `overflow` is set.
  - STOP → IDLE; `counter` holds its value.
  - START is a NOP.
  - CLEAR, LOAD and both ARM commands set `cmd_error` and are ignored.
- CLEAR_ERR clears `cmd_error` and `overflow` in any state. A new error on the same edge loses to the clear; only CLEAR_ERR itself is in effect.
- NOP has no effect in any state.
- `sync_in` edges outside ARMED_EXT are ignored. The edge detector keeps running, so a level already high on entry to ARMED_EXT does not trigger; only a fresh 0→1 does.
- Simultaneous command and event:
  - A STOP accepted on the same edge a delay expires, or a `sync_in` edge is detected, wins: the next state is IDLE.
  - A command accepted in RUNNING on the same edge as a wrap is applied after the increment.

## Timing
- Commands are registered. The effect is visible on outputs the cycle after the accepting edge.
- START accepted at edge k:
  - `auto_start`=1 after edge k.
  - The first increment appears after edge k+1, so RTO sees the pre-start value for one cycle with `auto_start` high.
- STOP at edge k: `auto_start`=0 and `counter` is frozen after edge k.
- ARM_DELAY D accepted at edge k: `auto_start` rises after edge k+D.
- `sync_in` rise to `auto_start` rise: SYNC_STAGES+1 edges (3 by default), ±1 cycle of asynchronous uncertainty.
- Reset is asserted asynchronously at any time. All outputs return to reset values immediately and any pending arm is discarded.

## Test plan
- Reset, LOAD 0x100, START, run 10 cycles, STOP → `counter`=0x109 or 0x10A per the latency rule; `auto_start` high for exactly 10 cycles; the frozen value holds for 20 further cycles.
- ARM_DELAY 5, then STOP at cycle 3 → `auto_start` never rises and `armed` drops. Repeat without STOP → `auto_start` rises exactly 5 edges after acceptance.
- ARM_EXT with `sync_in` already high → no start. Toggle `sync_in` 0→1 → `auto_start` rises 3 edges later; with COUNTER_STEP=4, `counter` advances 4 per cycle.
- LOAD 0xFFFF_FFFF_FFFF_FFFE, START → `counter` goes …FE, …FF, 0; `overflow`=1 sticky. CLEAR_ERR → `overflow`=0.
- LOAD while RUNNING → `cmd_error`=1 and `counter` unaffected. The same-edge STOP-vs-delay-expiry case → IDLE.
- Assert `s_axi_aresetn`=0 mid-RUNNING and mid-ARMED_DLY → all outputs are 0 asynchronously; after release, `cmd_ready`=1 one edge later.
